// File: rtl/flit_pkg.sv
// -----------------------------------------------------------------------------
// flit_pkg
//   Shared flit geometry for the VC ingress buffer and its FIFOs.
//   Default widths, field bit positions, the VC index type and small helpers
//   that pull the valid bit, tail bit and VC field out of a flit.
// -----------------------------------------------------------------------------
package flit_pkg;

  localparam int unsigned DEF_FLIT_WIDTH = 32;
  localparam int unsigned DEF_NUM_VCS    = 2;
  localparam int unsigned DEF_VC_LSB     = 0;
  localparam int unsigned DEF_VC_DEPTH   = 4;

  localparam int unsigned VC_W      = $clog2(DEF_NUM_VCS);
  localparam int unsigned VALID_BIT = DEF_FLIT_WIDTH - 1;
  localparam int unsigned TAIL_BIT  = DEF_FLIT_WIDTH - 2;

  typedef logic [VC_W-1:0]           vc_idx_t;
  typedef logic [DEF_FLIT_WIDTH-1:0] flit_t;

  function automatic logic flit_valid(input flit_t f);
    return f[VALID_BIT];
  endfunction

  function automatic logic flit_tail(input flit_t f);
    return f[TAIL_BIT];
  endfunction

  function automatic vc_idx_t flit_vc(input flit_t f);
    return f[DEF_VC_LSB +: VC_W];
  endfunction

endpackage

// File: rtl/flit_vc_ingress_buffer_vc_fifo.sv
// -----------------------------------------------------------------------------
// vc_fifo
//   One synchronous FIFO for a single virtual channel.
//   Ports:
//     clk, rst         : clock, synchronous active-high reset
//     push, push_data  : write strobe and data (ignored when full)
//     pop              : read strobe (ignored when empty)
//     head             : current head entry, valid when !empty
//     count            : number of stored entries
//     full, empty      : occupancy flags derived from count
//   Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
// -----------------------------------------------------------------------------
module vc_fifo
  import flit_pkg::*;
#(
  parameter  int unsigned WIDTH = DEF_FLIT_WIDTH,
  parameter  int unsigned DEPTH = DEF_VC_DEPTH,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only observed through count.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/flit_vc_ingress_buffer.sv
// -----------------------------------------------------------------------------
// flit_vc_ingress_buffer
//   Network-side responder for a bridge flit send port. Buffers incoming
//   flits in per-VC FIFOs, advertises per-VC space, and drains them to a
//   downstream consumer with round-robin VC arbitration and per-packet
//   VC locking (no interleaving within a packet).
//   Ports:
//     CLK, RST               : clock, synchronous active-high reset
//     put_flit, put_flit_valid : flit from bridge and enqueue strobe
//     get_non_full_vcs       : bit v set when VC v has a free entry
//     get_non_full_vcs_ready : bridge sampling strobe (no effect on state)
//     out_flit, out_vc       : head flit of the granted VC and its VC index
//     out_valid, out_ready   : output handshake
//     overflow               : sticky, a flit arrived for a full VC
// -----------------------------------------------------------------------------
module flit_vc_ingress_buffer
  import flit_pkg::*;
#(
  parameter  int unsigned FLIT_WIDTH = DEF_FLIT_WIDTH,
  parameter  int unsigned NUM_VCS    = DEF_NUM_VCS,
  parameter  int unsigned VC_LSB     = DEF_VC_LSB,
  parameter  int unsigned VC_DEPTH   = DEF_VC_DEPTH,
  localparam int unsigned VCW        = $clog2(NUM_VCS)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [FLIT_WIDTH-1:0] put_flit,
  input  logic                  put_flit_valid,
  output logic [NUM_VCS-1:0]    get_non_full_vcs,
  input  logic                  get_non_full_vcs_ready,
  output logic [FLIT_WIDTH-1:0] out_flit,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [VCW-1:0]        out_vc,
  output logic                  overflow
);

  localparam int unsigned CNT_W = $clog2(VC_DEPTH + 1);

  logic [FLIT_WIDTH-1:0] fifo_head  [NUM_VCS];
  logic [CNT_W-1:0]      fifo_count [NUM_VCS];
  logic [NUM_VCS-1:0]    fifo_full;
  logic [NUM_VCS-1:0]    fifo_empty;
  logic [NUM_VCS-1:0]    fifo_push;
  logic [NUM_VCS-1:0]    fifo_pop;

  logic           lock_q, lock_d;
  logic [VCW-1:0] lock_vc_q, lock_vc_d;
  logic [VCW-1:0] rr_last_q, rr_last_d;
  logic           overflow_q, overflow_d;

  logic           enq;
  logic [VCW-1:0] in_vc;
  logic [VCW-1:0] grant;
  logic           fire;
  logic           out_tail;

  // The sampling strobe is purely informational for the bridge.
  logic unused_ready;
  assign unused_ready = get_non_full_vcs_ready;

  assign enq   = put_flit_valid && put_flit[FLIT_WIDTH-1];
  assign in_vc = put_flit[VC_LSB +: VCW];

  for (genvar v = 0; v < NUM_VCS; v++) begin : g_vc
    assign fifo_push[v]        = enq && (in_vc == VCW'(v));
    assign fifo_pop[v]         = fire && (grant == VCW'(v));
    assign get_non_full_vcs[v] = (fifo_count[v] < CNT_W'(VC_DEPTH));

    vc_fifo #(
      .WIDTH (FLIT_WIDTH),
      .DEPTH (VC_DEPTH)
    ) u_fifo (
      .clk       (CLK),
      .rst       (RST),
      .push      (fifo_push[v]),
      .push_data (put_flit),
      .pop       (fifo_pop[v]),
      .head      (fifo_head[v]),
      .count     (fifo_count[v]),
      .full      (fifo_full[v]),
      .empty     (fifo_empty[v])
    );
  end

  // Grant: the locked VC if mid-packet, else the first non-empty VC after
  // rr_last. When nothing is pending the default is rr_last+1, which makes
  // out_vc read 0 straight out of reset.
  always_comb begin
    logic [VCW-1:0] cand;
    logic           found;
    grant = rr_last_q + VCW'(1);
    cand  = '0;
    found = 1'b0;
    if (lock_q) begin
      grant = lock_vc_q;
    end else begin
      for (int unsigned i = 1; i <= NUM_VCS; i++) begin
        cand = rr_last_q + VCW'(i);
        if (!found && !fifo_empty[cand]) begin
          grant = cand;
          found = 1'b1;
        end
      end
    end
  end

  assign out_valid = !fifo_empty[grant];
  assign out_flit  = out_valid ? fifo_head[grant] : '0;
  assign out_vc    = grant;
  assign out_tail  = out_flit[FLIT_WIDTH-2];
  assign fire      = out_valid && out_ready;
  assign overflow  = overflow_q;

  always_comb begin
    lock_d     = lock_q;
    lock_vc_d  = lock_vc_q;
    rr_last_d  = rr_last_q;
    // Full test uses the pre-edge count, so a same-cycle pop does not save it.
    overflow_d = overflow_q || (enq && fifo_full[in_vc]);
    if (fire) begin
      if (out_tail) begin
        lock_d    = 1'b0;
        rr_last_d = grant;
      end else begin
        lock_d    = 1'b1;
        lock_vc_d = grant;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      lock_q     <= 1'b0;
      lock_vc_q  <= '0;
      rr_last_q  <= VCW'(NUM_VCS - 1);
      overflow_q <= 1'b0;
    end else begin
      lock_q     <= lock_d;
      lock_vc_q  <= lock_vc_d;
      rr_last_q  <= rr_last_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: doc/flit_vc_ingress_buffer.md
Name: flit_vc_ingress_buffer

Overview:
Network-side responder for the flit send port that the AXI4 master/slave bridges drive. It accepts flits from a bridge (put_flit/put_flit_valid), buffers them in per-VC FIFOs, and advertises per-VC space on get_non_full_vcs. It drains buffered flits to a downstream consumer (router input or test sink) with round-robin VC arbitration and per-packet VC locking. It is used as a standalone network endpoint model and as the ingress stage of custom routers.

Parameters:
FLIT_WIDTH, 32, total flit width; bit [FLIT_WIDTH-1] is the flit valid bit, bit [FLIT_WIDTH-2] is the tail bit.
NUM_VCS, 2, number of virtual channels (power of two, >=2).
VC_LSB, 0, LSB position of the VC field inside the flit.
VC_DEPTH, 4, flit entries per VC FIFO (>=2).

Ports:
CLK  input  1  clock; all state on rising edge.
RST  input  1  synchronous, active-high reset.
put_flit  input  FLIT_WIDTH  flit from the bridge.
put_flit_valid  input  1  enqueue strobe.
get_non_full_vcs  output  NUM_VCS  bit v=1 when VC v has at least one free entry.
get_non_full_vcs_ready  input  1  bridge sampling strobe; informational only, no effect on state.
out_flit  output  FLIT_WIDTH  head flit of the granted VC; all zeros when out_valid=0.
out_valid  output  1  granted VC is non-empty.
out_ready  input  1  consumer accepts out_flit.
out_vc  output  $clog2(NUM_VCS)  VC of out_flit.
overflow  output  1  sticky; a flit arrived for a full VC.

Behaviour:
- Reset: RST=1 at a clock edge clears all FIFO counts and pointers, clears the lock, sets rr_last=NUM_VCS-1 (so VC0 wins first), and clears overflow.
  - Output values after reset: get_non_full_vcs = all ones, out_valid=0, out_flit=0, out_vc=0.
  - Reset mid-packet discards all buffered flits and the lock.
- Enqueue condition: put_flit_valid=1 AND put_flit[FLIT_WIDTH-1]=1.
  - vc = put_flit[VC_LSB +: $clog2(NUM_VCS)].
  - The flit is written to FIFO[vc] at the edge.
  - If the strobe is set but the valid bit is clear, the flit is ignored.
- Full VC: an enqueue to a VC whose count is VC_DEPTH is dropped and overflow sets to 1 (cleared only by reset).
  - This applies even if the same VC pops in the same cycle; the decision uses the pre-edge count.
- Non-full flags: get_non_full_vcs[v] = (count[v] < VC_DEPTH), combinational from registered counts.
  - A push is reflected on the cycle after the edge.
- Grant selection: if locked, grant = lock_vc; else grant = first non-empty VC searching from rr_last+1 with wrap-around.
  - out_valid = count[grant] != 0.
  - out_flit and out_vc come combinationally from the granted head, with zero latency from the FIFO head.
  - Enqueue-to-out_valid latency is 1 cycle.
- Pop: occurs when out_valid & out_ready.
  - Pop of a non-tail flit: lock=1, lock_vc=grant.
  - Pop of a tail flit: lock=0, rr_last=grant.
  - Single-flit packets (tail set) never lock.
- While locked and the locked VC is empty, out_valid=0 even if other VCs hold flits; no interleaving within a packet.
- Simultaneous push and pop on the same VC: count unchanged; the FIFO pointer wraps modulo VC_DEPTH.
- out_flit is held stable while out_valid=1 and out_ready=0.

Decomposition:
- Shared package flit_pkg holds:
  - the bit positions for the valid bit, tail bit and VC field;
  - the VC index typedef vc_idx_t = logic [$clog2(NUM_VCS)-1:0];
  - a helper function for flit field extraction.
- Sub-module vc_fifo provides one synchronous FIFO with count, full/empty, head read, and push/pop.
  - It is instantiated NUM_VCS times via generate.
  - The arbitration, lock and overflow logic stays in the top level.

Test Plan:
- Reset then idle: get_non_full_vcs=2'b11, out_valid=0, out_flit=0, overflow=0.
- Single flit 0xC000_0001 (valid, tail, VC1) with out_ready=1: out_valid=1 next cycle, out_vc=1, flit popped, get_non_full_vcs stays 2'b11.
- 3-flit packet on VC0 (head/body non-tail, tail 0xC000_0000) interleaved cycle-by-cycle with VC1 single flits, out_ready=1: all 3 VC0 flits leave consecutively before any VC1 flit; afterwards VC1 is drained.
- Fill VC0 with 4 flits while out_ready=0: get_non_full_vcs[0]=0 after the 4th. A 5th put is dropped, overflow=1, and exactly 4 flits later drain in order.
- Both VCs hold single-flit packets, out_ready=1: grants alternate VC0, VC1, VC0, VC1.
- Assert RST mid-packet (lock held on VC1): next cycle out_valid=0, get_non_full_vcs=2'b11, overflow=0. A new VC0 flit is then granted immediately (lock cleared).
